cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
// Coprocessor-0 exception/interrupt controller in the M stage. Collects the
// exception code, branch-delay flag and PC of the instruction in M plus the
// external interrupt lines, and produces the pipeline-wide flush request
// `req`, the handler base address and the return address used by ERET. The
// IF/ID register and the other pipeline registers consume req/ebase/epc_out.
// PARAMETERS
// EBASE  32'h0000_4180  handler entry address driven on ebase_out
// PRID   32'h2022_0001  read-only value of PRId (reg 15)
// PORTS
// clk          in   1   clock
// reset        in   1   reset, synchronous, active-high
// we           in   1   MTC0 write strobe (M stage)
// addr         in   5   CP0 register number for MTC0/MFC0
// wdata        in   32  MTC0 write data
// rdata        out  32  MFC0 read data, combinational
// m_pc         in   32  PC of instruction in M
// m_bd         in   1   instruction in M sits in a branch delay slot
// m_exc_code   in   5   exception code from M, 0 = none
// m_eret       in   1   ERET in M
// hw_int       in   6   external interrupt lines, level-sensitive
// req          out  1   take exception/interrupt this cycle (flush all)
// ebase_out    out  32  handler address, constant EBASE
// epc_out      out  32  current EPC register value
// BEHAVIOUR
// - Registers: SR(12){IM[15:10],EXL[1],IE[0]}, Cause(13){BD[31],IP[15:10],
//   ExcCode[6:2]}, EPC(14), PRId(15). Unimplemented bits read 0.
// - Reset: SR=0, Cause=0, EPC=0 -> req=0, epc_out=0, rdata=0 for any addr
//   except 15 (PRID).
// - int_req = |(IP_src & SR.IM) & SR.IE & ~SR.EXL, IP_src = hw_int (combinational).
// - exc_req = (m_exc_code != 0) & ~SR.EXL. req = int_req | exc_req, comb.
// - Priority: interrupt over exception; req over ERET over MTC0.
// - On req (next edge): EXL<=1; ExcCode<= int_req ? 0 : m_exc_code;
//   BD<=m_bd; EPC<= m_bd ? {m_pc[31:2],2'b00}-4 : {m_pc[31:2],2'b00}.
//   Concurrent MTC0/ERET in same cycle are discarded.
// - Cause.IP <= hw_int (or timer-merged value) every cycle, incl. during req.
// - ERET (no req): EXL<=0 at edge; epc_out is the pre-edge EPC register,
//   no bypass of a same-cycle MTC0 to EPC.
// - MTC0 (we, no req, no eret): addr 12 writes IM/EXL/IE; 14 writes EPC
//   (bits[1:0] forced 0); 13 writes nothing; others ignored.
// - MFC0: rdata = register[addr] with current (pre-edge) contents, 0 if unmapped.
// - Reset mid-handler clears EXL; pending exception inputs ignored that edge.
// CONFIGURATION
// CP0_TIMER_EN defined: Count(9) increments every cycle (wraps 2^32-1 -> 0),
//   Compare(11) R/W; timer_irq sets on edge where Count==Compare-1 (i.e.
//   Count reaches Compare), clears on MTC0 to Compare or reset;
//   IP_src[5] = hw_int[5] | timer_irq. MTC0 to Count loads it; reset Count=0,
//   Compare=32'hFFFF_FFFF.
// CP0_TIMER_EN undefined: regs 9/11 read 0, writes ignored, IP_src = hw_int.
// TESTING
// 1) reset, SR=32'h0000_0401 via MTC0, hw_int=6'b000001 -> req=1 next cycle,
//    ExcCode=0, EXL=1, req drops to 0 after edge.
// 2) m_exc_code=5'd4, m_pc=32'h3010, m_bd=1 -> req=1, EPC=32'h300C,
//    Cause=32'h8000_0010 (BD=1, ExcCode=4).
// 3) EXL=1, m_exc_code=5'd10 -> req=0, no register change; then m_eret=1 ->
//    epc_out=EPC that cycle, EXL=0 after edge.
// 4) same cycle: m_exc_code=12, we=1 addr=14 wdata=32'h5000, m_eret=1 ->
//    req=1, EPC=m_pc, MTC0 and ERET dropped.
// 5) addr=15 -> rdata=PRID; addr=3 -> rdata=0; MTC0 EPC=32'h3007 -> reads 32'h3004.
// 6) CP0_TIMER_EN: Compare=5, Count=0, SR=32'h0000_8001 -> req when Count=5;
//    MTC0 Compare clears IP[15].

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt controller, M stage; optional timer under CP0_TIMER_EN
module cp0_exc_ctrl #(
  parameter logic [31:0] EBASE = 32'h0000_4180,
  parameter logic [31:0] PRID  = 32'h2022_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] ebase_out,
  output logic [31:0] epc_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  ip_src;
  logic        int_req;
  logic        exc_req;
  logic        mtc0;
  logic [31:0] pc_aligned;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_irq_q, timer_irq_d;

  assign ip_src = {hw_int[5] | timer_irq_q, hw_int[4:0]};
`else
  assign ip_src = hw_int;
`endif

  assign ebase_out = EBASE;
  assign epc_out   = epc_q;
  assign sr_val    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
  assign cause_val = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};

  always_comb begin
    int_req    = (|(ip_src & im_q)) & ie_q & ~exl_q;
    exc_req    = (m_exc_code != 5'd0) & ~exl_q;
    req        = int_req | exc_req;
    // A flush or ERET in the same cycle swallows any MTC0 in M.
    mtc0       = we & ~req & ~m_eret;
    pc_aligned = m_pc & ~32'd3;
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = ip_src;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : m_exc_code;
      bd_d       = m_bd;
      epc_d      = m_bd ? (pc_aligned - 32'd4) : pc_aligned;
    end else if (m_eret) begin
      exl_d = 1'b0;
    end else if (mtc0) begin
      if (addr == 5'd12) begin
        im_d  = wdata[15:10];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end else if (addr == 5'd14) begin
        epc_d = wdata & ~32'd3;
      end
    end
  end

`ifdef CP0_TIMER_EN
  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    timer_irq_d = timer_irq_q;
    // Fires on the edge where Count steps onto Compare.
    if (count_q == compare_q - 32'd1) timer_irq_d = 1'b1;
    if (mtc0 && addr == 5'd9) count_d = wdata;
    if (mtc0 && addr == 5'd11) begin
      compare_d   = wdata;
      timer_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 32'd0;
      compare_q   <= 32'hFFFF_FFFF;
      timer_irq_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_irq_q <= timer_irq_d;
    end
  end
`endif

  always_comb begin
    rdata = 32'd0;
    case (addr)
      5'd12:   rdata = sr_val;
      5'd13:   rdata = cause_val;
      5'd14:   rdata = epc_q;
      5'd15:   rdata = PRID;
`ifdef CP0_TIMER_EN
      5'd9:    rdata = count_q;
      5'd11:   rdata = compare_q;
`endif
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] ebase_out;
  logic [31:0] epc_out;

  int passed = 0;
  int total  = 0;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .m_pc       (m_pc),
    .m_bd       (m_bd),
    .m_exc_code (m_exc_code),
    .m_eret     (m_eret),
    .hw_int     (hw_int),
    .req        (req),
    .ebase_out  (ebase_out),
    .epc_out    (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    tick();
    we = 1'b0;
    wdata = 32'd0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0;
    m_pc = 32'd0; m_bd = 1'b0; m_exc_code = 5'd0; m_eret = 1'b0; hw_int = 6'd0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    #1;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_epc_out", epc_out, 32'd0);
    check("ebase", ebase_out, 32'h0000_4180);
    chk_reg("rst_sr", 5'd12, 32'd0);
    chk_reg("rst_cause", 5'd13, 32'd0);
    chk_reg("rst_prid", 5'd15, 32'h2022_0001);

    // interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    chk_reg("sr_write", 5'd12, 32'h0000_0401);
    m_pc = 32'h2000;
    hw_int = 6'b000001;
    #1;
    check("int_req", {31'd0, req}, 32'd1);
    tick();
    check("int_req_masked_exl", {31'd0, req}, 32'd0);
    chk_reg("int_sr", 5'd12, 32'h0000_0403);
    chk_reg("int_cause", 5'd13, 32'h0000_0400);
    check("int_epc", epc_out, 32'h2000);
    hw_int = 6'd0;
    tick();
    chk_reg("cause_ip_clear", 5'd13, 32'd0);
    m_eret = 1'b1;
    #1;
    check("eret1_epc_out", epc_out, 32'h2000);
    tick();
    m_eret = 1'b0;
    chk_reg("eret1_sr", 5'd12, 32'h0000_0401);

    // exception in delay slot
    m_exc_code = 5'd4; m_pc = 32'h3010; m_bd = 1'b1;
    #1;
    check("exc_req", {31'd0, req}, 32'd1);
    tick();
    m_exc_code = 5'd0; m_bd = 1'b0;
    check("exc_epc", epc_out, 32'h300C);
    chk_reg("exc_cause", 5'd13, 32'h8000_0010);
    chk_reg("exc_sr", 5'd12, 32'h0000_0403);

    // exception masked while EXL, then ERET
    m_exc_code = 5'd10;
    #1;
    check("exl_mask_req", {31'd0, req}, 32'd0);
    tick();
    m_exc_code = 5'd0;
    chk_reg("exl_mask_cause", 5'd13, 32'h8000_0010);
    check("exl_mask_epc", epc_out, 32'h300C);
    m_eret = 1'b1;
    #1;
    check("eret2_epc_out", epc_out, 32'h300C);
    tick();
    m_eret = 1'b0;
    chk_reg("eret2_sr", 5'd12, 32'h0000_0401);

    // exception beats concurrent MTC0 and ERET
    m_exc_code = 5'd12; we = 1'b1; addr = 5'd14; wdata = 32'h5000; m_eret = 1'b1;
    m_pc = 32'h3100; m_bd = 1'b0;
    #1;
    check("prio_req", {31'd0, req}, 32'd1);
    tick();
    m_exc_code = 5'd0; we = 1'b0; wdata = 32'd0; m_eret = 1'b0;
    check("prio_epc", epc_out, 32'h3100);
    chk_reg("prio_sr", 5'd12, 32'h0000_0403);
    chk_reg("prio_cause", 5'd13, 32'h0000_0030);
    m_eret = 1'b1;
    tick();
    m_eret = 1'b0;

    // interrupt wins over exception
    hw_int = 6'b000001; m_exc_code = 5'd4; m_bd = 1'b1; m_pc = 32'h4000;
    #1;
    check("int_over_exc_req", {31'd0, req}, 32'd1);
    tick();
    hw_int = 6'd0; m_exc_code = 5'd0; m_bd = 1'b0;
    chk_reg("int_over_exc_cause", 5'd13, 32'h8000_0400);
    check("int_over_exc_epc", epc_out, 32'h3FFC);

    // MFC0 map and EPC write alignment
    chk_reg("mfc0_prid", 5'd15, 32'h2022_0001);
    chk_reg("mfc0_unmapped", 5'd3, 32'd0);
    mtc0(5'd14, 32'h3007);
    chk_reg("epc_align", 5'd14, 32'h3004);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk_reg("cause_ro", 5'd13, 32'h8000_0000);
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'h1234);
    chk_reg("no_timer_count", 5'd9, 32'd0);
    chk_reg("no_timer_compare", 5'd11, 32'd0);
`endif

    // reset while in handler discards pending exception
    m_eret = 1'b1;
    tick();
    m_eret = 1'b0;
    m_exc_code = 5'd4; m_pc = 32'h6000;
    tick();
    reset = 1'b1; m_exc_code = 5'd5;
    tick();
    reset = 1'b0; m_exc_code = 5'd0;
    chk_reg("rst2_sr", 5'd12, 32'd0);
    chk_reg("rst2_cause", 5'd13, 32'd0);
    check("rst2_epc", epc_out, 32'd0);
    check("rst2_req", {31'd0, req}, 32'd0);

`ifdef CP0_TIMER_EN
    chk_reg("tmr_compare_rst", 5'd11, 32'hFFFF_FFFF);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    chk_reg("tmr_count1", 5'd9, 32'd1);
    check("tmr_no_req", {31'd0, req}, 32'd0);
    tick(); tick(); tick();
    check("tmr_no_req4", {31'd0, req}, 32'd0);
    tick();
    chk_reg("tmr_count5", 5'd9, 32'd5);
    check("tmr_req", {31'd0, req}, 32'd1);
    tick();
    chk_reg("tmr_cause_ip7", 5'd13, 32'h0000_8000);
    mtc0(5'd11, 32'h100);
    tick();
    chk_reg("tmr_cause_clr", 5'd13, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
